// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared FSM encodings and constants for period_meter
package period_meter_pkg;

  localparam int C_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge pulse, reusable for sensor pins
module sync_edge_detect
  import period_meter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic [C_SYNC_STAGES-1:0] r_sync;
  logic                     r_prev;

  // Shift the pin through the synchronizer and remember the last synchronized level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[C_SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[C_SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[C_SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures input square-wave period in clock cycles; optional averaging via PERIOD_METER_AVG_EN
module period_meter
  import period_meter_pkg::*;
#(
  parameter int C_BITS     = 16,
  parameter int C_AVG_LOG2 = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_sig,
  output logic [C_BITS-1:0] o_period,
  output logic              o_valid,
  output logic              o_timeout
);

  localparam logic [C_BITS-1:0] C_MAX = '1;
  localparam logic [C_BITS-1:0] C_ONE = {{(C_BITS-1){1'b0}}, 1'b1};

  logic              w_edge;
  state_t            r_state;
  logic [C_BITS-1:0] r_count;

  sync_edge_detect u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sig),
    .o_edge  (w_edge)
  );

`ifdef PERIOD_METER_AVG_EN
  localparam logic [C_AVG_LOG2-1:0] C_GRP_ONE = {{(C_AVG_LOG2-1){1'b0}}, 1'b1};

  logic [C_BITS+C_AVG_LOG2-1:0] r_acc;
  logic [C_AVG_LOG2-1:0]        r_grp;
  logic [C_BITS+C_AVG_LOG2-1:0] w_sum;

  // Running group sum including the period that is closing this cycle
  assign w_sum = r_acc + {{C_AVG_LOG2{1'b0}}, r_count};
`endif

  // Measurement FSM: counter runs between consecutive rising edges, outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      r_acc     <= '0;
      r_grp     <= '0;
`endif
    end else begin
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      if (!i_enable) begin
        // Drop any partial measurement; two edges are needed after re-enable
        r_state <= ST_IDLE;
        r_count <= '0;
`ifdef PERIOD_METER_AVG_EN
        r_acc   <= '0;
        r_grp   <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARM;
          ST_ARM: begin
            if (w_edge) begin
              r_state <= ST_MEAS;
              r_count <= C_ONE;
            end
          end
          ST_MEAS: begin
            if (w_edge) begin
              // An edge in the saturating cycle still yields a normal result
              r_count <= C_ONE;
`ifdef PERIOD_METER_AVG_EN
              if (r_grp == '1) begin
                o_period <= w_sum[C_BITS+C_AVG_LOG2-1:C_AVG_LOG2];
                o_valid  <= 1'b1;
                r_acc    <= '0;
                r_grp    <= '0;
              end else begin
                r_acc <= w_sum;
                r_grp <= r_grp + C_GRP_ONE;
              end
`else
              o_period <= r_count;
              o_valid  <= 1'b1;
`endif
            end else if (r_count == C_MAX) begin
              o_timeout <= 1'b1;
              r_state   <= ST_ARM;
              r_count   <= '0;
`ifdef PERIOD_METER_AVG_EN
              r_acc     <= '0;
              r_grp     <= '0;
`endif
            end else begin
              r_count <= r_count + C_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;

  localparam int C_BITS     = 8;
  localparam int C_AVG_LOG2 = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic              sig   = 1'b0;
  logic [C_BITS-1:0] period;
  logic              valid;
  logic              tout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int both_cnt = 0;
  int vq[$];
  int vcyc[$];

  always #5 clk = ~clk;

  period_meter #(
    .C_BITS     (C_BITS),
    .C_AVG_LOG2 (C_AVG_LOG2)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (en),
    .i_sig     (sig),
    .o_period  (period),
    .o_valid   (valid),
    .o_timeout (tout)
  );

  // Record every result and timeout pulse, sampled 1 ns after the active edge
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (valid) begin
      vq.push_back(int'(period));
      vcyc.push_back(cyc);
    end
    if (tout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (valid && tout) both_cnt++;
  end

  task automatic pulse(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic tail();
    sig = 1'b1;
    repeat (6) @(negedge clk);
    sig = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_meas();
    @(negedge clk);
    en  = 1'b0;
    sig = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    vq.delete();
    vcyc.delete();
    to_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (period !== 8'd0) begin n_bad++; $display("FAIL reset_period got %0d want 0", period); end
    n_cmp++;
    if (valid !== 1'b0 || tout !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got valid=%b timeout=%b want 0/0", valid, tout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div16();
    int exp_q[$];
    exp_q = '{16, 16, 16, 16, 16};
    start_meas();
    repeat (5) pulse(8, 8);
    tail();
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL div16_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL div16_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      n_cmp++;
      if (vcyc[i] - vcyc[i-1] != 16) begin
        n_bad++; $display("FAIL div16_spacing[%0d] got %0d want 16", i, vcyc[i] - vcyc[i-1]);
      end
    end
  endtask

  task automatic test_switch();
    int exp_q[$];
    exp_q = '{6, 6, 6, 40, 40, 40};
    start_meas();
    repeat (3) pulse(3, 3);
    repeat (3) pulse(20, 20);
    tail();
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL switch_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL switch_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int rise_cyc;
    int exp_q[$];
    exp_q = '{10, 10};
    start_meas();
    rise_cyc = cyc;
    pulse(3, 3);
    repeat (300) @(negedge clk);
    n_cmp++;
    if (to_cnt != 1) begin n_bad++; $display("FAIL timeout_pulses got %0d want 1", to_cnt); end
    n_cmp++;
    if (to_cyc - rise_cyc != 258) begin
      n_bad++; $display("FAIL timeout_latency got %0d want 258", to_cyc - rise_cyc);
    end
    n_cmp++;
    if (period !== 8'd40) begin n_bad++; $display("FAIL timeout_period_held got %0d want 40", period); end
    n_cmp++;
    if (vq.size() != 0) begin n_bad++; $display("FAIL timeout_no_result got %0d want 0", vq.size()); end
    pulse(5, 5);
    pulse(5, 5);
    tail();
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL after_timeout_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL after_timeout_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_max_period();
    int exp_q[$];
    exp_q = '{255, 255};
    start_meas();
    pulse(128, 127);
    pulse(128, 127);
    tail();
    n_cmp++;
    if (to_cnt != 0) begin n_bad++; $display("FAIL max_no_timeout got %0d want 0", to_cnt); end
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL max_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL max_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_disable();
    int exp_q[$];
    exp_q = '{12, 14, 14};
    start_meas();
    pulse(6, 6);
    sig = 1'b1;
    repeat (6) @(negedge clk);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (vq.size() != 1) begin n_bad++; $display("FAIL disable_no_valid got %0d want 1", vq.size()); end
    n_cmp++;
    if (period !== 8'd12) begin n_bad++; $display("FAIL disable_period_held got %0d want 12", period); end
    en = 1'b1;
    repeat (4) @(negedge clk);
    pulse(7, 7);
    pulse(7, 7);
    tail();
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL reenable_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL reenable_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int exp_q[$];
    exp_q = '{10, 10, 10};
    start_meas();
    pulse(5, 5);
    pulse(5, 5);
    sig = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (period !== 8'd10) begin n_bad++; $display("FAIL prereset_period got %0d want 10", period); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (period !== 8'd0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got period=%0d valid=%b want 0/0", period, valid);
    end
    repeat (3) @(negedge clk);
    sig   = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vq.delete();
    repeat (3) pulse(5, 5);
    tail();
    n_cmp++;
    if (vq.size() != exp_q.size()) begin
      n_bad++; $display("FAIL postreset_count got %0d want %0d", vq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= vq.size() || vq[i] != exp_q[i]) begin
        n_bad++; $display("FAIL postreset_period[%0d] got %0d want %0d", i, (i < vq.size()) ? vq[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_average();
    start_meas();
    pulse(5, 5);
    pulse(6, 6);
    pulse(5, 5);
    pulse(6, 6);
    pulse(5, 5);
    tail();
    n_cmp++;
    if (vq.size() != 1) begin n_bad++; $display("FAIL avg_count got %0d want 1", vq.size()); end
    n_cmp++;
    if (vq.size() < 1 || vq[0] != 11) begin
      n_bad++; $display("FAIL avg_value got %0d want 11", (vq.size() > 0) ? vq[0] : -1);
    end
    n_cmp++;
    if (period !== 8'd11) begin n_bad++; $display("FAIL avg_period_held got %0d want 11", period); end
  endtask

  initial begin
    test_reset();
`ifdef PERIOD_METER_AVG_EN
    test_average();
`else
    test_div16();
    test_switch();
    test_timeout();
    test_max_period();
    test_disable();
    test_async_reset();
`endif
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("FAIL valid_and_timeout got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
